dircc_gals_compute_engine: RTL and testbench

// - Next-generation compute handler for the GALS heat processing element. It sweeps NUM_DEVICES local device

---
 rtl/dircc_gals_compute_engine_if.sv | 38 +++
 rtl/dircc_gals_compute_engine.sv | 139 +++++++++++++
 tb/tb_dircc_gals_compute_engine.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dircc_gals_compute_engine_if.sv
// State-RAM and send-path signals of the GALS heat compute engine.
// The engine drives this interface as master; the RAM and send handler sit on the slave side.
interface dircc_gals_compute_engine_if #(
  parameter int ADDR_W  = 2,
  parameter int TEMP_W  = 16,
  parameter int ITER_W  = 16,
  parameter int STATE_W = 53
);
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [STATE_W-1:0] mem_rd_data;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [STATE_W-1:0] mem_wr_data;
  logic               send_valid;
  logic               send_ready;
  logic [ADDR_W-1:0]  send_addr;
  logic [TEMP_W-1:0]  send_temp;
  logic [ITER_W-1:0]  send_iter;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output send_valid,
    input  send_ready,
    output send_addr, send_temp, send_iter
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  send_valid,
    output send_ready,
    input  send_addr, send_temp, send_iter
  );
endinterface

// File: rtl/dircc_gals_compute_engine.sv
// Compute handler for the GALS heat PE: sweeps local devices, averages neighbour sums, writes back and sends.
// Optional statistics counters are enabled with `define DIRCC_COMPUTE_STATS_EN.
module dircc_gals_compute_engine #(
  parameter int NUM_DEVICES = 4,
  parameter int ADDR_W      = 2,
  parameter int TEMP_W      = 16,
  parameter int NEIGH_LOG2  = 2,
  parameter int CNT_W       = 3,
  parameter int SUM_W       = 18,
  parameter int ITER_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
`ifdef DIRCC_COMPUTE_STATS_EN
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_stalls,
`endif
  dircc_gals_compute_engine_if.master bus
);

  localparam int STATE_W    = ITER_W + CNT_W + SUM_W + TEMP_W;
  localparam int NEIGHBOURS = 1 << NEIGH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_EVAL, S_WR, S_SEND, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic [TEMP_W-1:0]  new_temp;
  logic [ITER_W-1:0]  iter_next;
  logic               dev_ready;

  // Over-full counts are treated as ready, so compare with >= rather than ==.
  assign new_temp  = TEMP_W'(sum_q >> NEIGH_LOG2);
  assign iter_next = iter_q + ITER_W'(1);
  assign dev_ready = (count_q >= CNT_W'(NEIGHBOURS)) && (iter_q < max_iter);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    count_d = count_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        iter_d  = bus.mem_rd_data[STATE_W-1 -: ITER_W];
        count_d = bus.mem_rd_data[TEMP_W+SUM_W +: CNT_W];
        sum_d   = bus.mem_rd_data[TEMP_W +: SUM_W];
        state_d = S_EVAL;
      end
      S_EVAL: state_d = dev_ready ? S_WR : S_NEXT;
      S_WR:   state_d = S_SEND;
      S_SEND: begin
        if (bus.send_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == ADDR_W'(NUM_DEVICES - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      iter_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  // Bus fields are gated by state so every output reads zero outside its strobe.
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign bus.mem_rd_en   = (state_q == S_RD);
  assign bus.mem_rd_addr = bus.mem_rd_en ? idx_q : '0;
  assign bus.mem_wr_en   = (state_q == S_WR);
  assign bus.mem_wr_addr = bus.mem_wr_en ? idx_q : '0;
  assign bus.mem_wr_data = bus.mem_wr_en ? {iter_next, CNT_W'(0), SUM_W'(0), new_temp} : '0;
  assign bus.send_valid  = (state_q == S_SEND);
  assign bus.send_addr   = bus.send_valid ? idx_q : '0;
  assign bus.send_temp   = bus.send_valid ? new_temp : '0;
  assign bus.send_iter   = bus.send_valid ? iter_next : '0;

`ifdef DIRCC_COMPUTE_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_stalls_d  = stat_stalls_q;
    if (state_q == S_WR) stat_updates_d = stat_updates_q + 32'd1;
    if ((state_q == S_SEND) && !bus.send_ready) stat_stalls_d = stat_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_updates_q <= stat_updates_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_dircc_gals_compute_engine.sv
// Scoreboard bench for dircc_gals_compute_engine: directed device states, hand-computed writes and sends.
// Stats counters are checked only when DIRCC_COMPUTE_STATS_EN is defined.
module tb_dircc_gals_compute_engine;

  localparam int NUM_DEVICES = 4;
  localparam int ADDR_W      = 2;
  localparam int TEMP_W      = 16;
  localparam int NEIGH_LOG2  = 2;
  localparam int CNT_W       = 3;
  localparam int SUM_W       = 18;
  localparam int ITER_W      = 16;
  localparam int STATE_W     = ITER_W + CNT_W + SUM_W + TEMP_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              busy;
  logic              done;
`ifdef DIRCC_COMPUTE_STATS_EN
  logic [31:0]       stat_updates;
  logic [31:0]       stat_stalls;
`endif

  dircc_gals_compute_engine_if #(
    .ADDR_W(ADDR_W), .TEMP_W(TEMP_W), .ITER_W(ITER_W), .STATE_W(STATE_W)
  ) bus ();

  dircc_gals_compute_engine #(
    .NUM_DEVICES(NUM_DEVICES), .ADDR_W(ADDR_W), .TEMP_W(TEMP_W), .NEIGH_LOG2(NEIGH_LOG2),
    .CNT_W(CNT_W), .SUM_W(SUM_W), .ITER_W(ITER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .max_iter     (max_iter),
    .busy         (busy),
    .done         (done),
`ifdef DIRCC_COMPUTE_STATS_EN
    .stat_updates (stat_updates),
    .stat_stalls  (stat_stalls),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // State RAM model with a registered one-cycle read and a bench-side load port.
  logic [STATE_W-1:0] mem [NUM_DEVICES];
  logic [STATE_W-1:0] rd_data_q;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [STATE_W-1:0] load_data;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_rd_addr];
  end
  assign bus.mem_rd_data = rd_data_q;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W+STATE_W-1:0]       wr_exp [$];
  logic [ADDR_W+TEMP_W+ITER_W-1:0] send_exp [$];

  function automatic logic [STATE_W-1:0] mkState(input logic [ITER_W-1:0] iter,
      input logic [CNT_W-1:0] count, input logic [SUM_W-1:0] sum, input logic [TEMP_W-1:0] temp);
    return {iter, count, sum, temp};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [63:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %h expected nothing", name, actual);
  endtask

  task automatic expectUpdate(input int a, input logic [ITER_W-1:0] new_iter, input logic [TEMP_W-1:0] new_temp);
    logic [ADDR_W-1:0] aa;
    aa = a[ADDR_W-1:0];
    wr_exp.push_back({aa, mkState(new_iter, '0, '0, new_temp)});
    send_exp.push_back({aa, new_temp, new_iter});
  endtask

  task automatic loadDev(input int a, input logic [STATE_W-1:0] w);
    load_en   = 1'b1;
    load_addr = a[ADDR_W-1:0];
    load_data = w;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) reportFail(name, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {busy, done, bus.mem_rd_en, bus.mem_rd_addr, bus.mem_wr_en, bus.mem_wr_addr,
                       bus.send_valid, bus.send_addr, bus.send_temp, bus.send_iter}, 64'd0);
    checkOutput({name, "_wdata"}, 64'(bus.mem_wr_data), 64'd0);
  endtask

  // Monitor: every write strobe and every send handshake consumes the oldest expectation.
  initial begin
    logic [ADDR_W+STATE_W-1:0]       wexp;
    logic [ADDR_W+TEMP_W+ITER_W-1:0] sexp;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (bus.mem_wr_en === 1'b1) begin
          if (wr_exp.size() == 0) reportFail("unexpected_write", 64'({bus.mem_wr_addr, bus.mem_wr_data}));
          else begin
            wexp = wr_exp.pop_front();
            checkOutput("mem_write", 64'({bus.mem_wr_addr, bus.mem_wr_data}), 64'(wexp));
          end
        end
        if (bus.send_valid === 1'b1 && bus.send_ready === 1'b1) begin
          if (send_exp.size() == 0) reportFail("unexpected_send", {bus.send_addr, bus.send_temp, bus.send_iter});
          else begin
            sexp = send_exp.pop_front();
            checkOutput("send", 64'({bus.send_addr, bus.send_temp, bus.send_iter}), 64'(sexp));
          end
        end
      end
    end
  end

  initial begin
    logic [ADDR_W+TEMP_W+ITER_W-1:0] cap;
    bit seen;
    int done_cyc;
    reset = 1'b1; start = 1'b0; max_iter = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus.send_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_state");
    @(posedge clk);
    #1 reset = 1'b0;

    // Sweep A: dev1 short of contributions, dev3 exercises truncation of the full-scale sum.
    loadDev(0, mkState(16'd0, 3'd4, 18'd400, 16'd0));
    loadDev(1, mkState(16'd0, 3'd3, 18'd300, 16'd7));
    loadDev(2, mkState(16'd0, 3'd4, 18'd800, 16'd5));
    loadDev(3, mkState(16'd0, 3'd4, 18'h3FFFF, 16'd0));
    max_iter = 16'd10;
    bus.send_ready = 1'b1;
    expectUpdate(0, 16'd1, 16'd100);
    expectUpdate(2, 16'd1, 16'd200);
    expectUpdate(3, 16'd1, 16'hFFFF);
    applyStimulus();
    waitDone("sweepA_done");
    checkOutput("dev1_untouched", 64'(mem[1]), 64'(mkState(16'd0, 3'd3, 18'd300, 16'd7)));
    checkOutput("dev0_written", 64'(mem[0]), 64'(mkState(16'd1, 3'd0, 18'd0, 16'd100)));
`ifdef DIRCC_COMPUTE_STATS_EN
    checkOutput("stat_updates_A", 64'(stat_updates), 64'd3);
    checkOutput("stat_stalls_A", 64'(stat_stalls), 64'd0);
`endif

    // Sweep B: dev0 stalls 5 cycles on send_ready; dev2 sum=7 averages to 1.
    loadDev(0, mkState(16'd2, 3'd4, 18'd16, 16'd9));
    loadDev(1, mkState(16'd10, 3'd4, 18'd40, 16'd0));
    loadDev(2, mkState(16'd0, 3'd4, 18'd7, 16'd0));
    loadDev(3, mkState(16'd0, 3'd2, 18'd0, 16'd0));
    bus.send_ready = 1'b0;
    expectUpdate(0, 16'd3, 16'd4);
    expectUpdate(2, 16'd1, 16'd1);
    applyStimulus();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (bus.send_valid) seen = 1'b1;
    end
    if (!seen) begin
      $display("[TB] FAIL send_valid_timeout: got 0 expected 1");
      $fatal(1, "[TB] send_valid never asserted");
    end
    cap = {bus.send_addr, bus.send_temp, bus.send_iter};
    checkOutput("stall_fields", 64'(cap), 64'({2'd0, 16'd4, 16'd3}));
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("stall_hold", 64'({bus.send_valid, bus.send_addr, bus.send_temp, bus.send_iter}),
                  64'({1'b1, cap}));
    end
    @(posedge clk);
    #1 bus.send_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_last", 64'({bus.send_valid, bus.send_addr, bus.send_temp, bus.send_iter}),
                64'({1'b1, cap}));
    @(negedge clk);
    checkOutput("valid_drops", 64'(bus.send_valid), 64'd0);
    @(posedge clk);
    #1;
    waitDone("sweepB_done");
`ifdef DIRCC_COMPUTE_STATS_EN
    checkOutput("stat_updates_B", 64'(stat_updates), 64'd5);
    checkOutput("stat_stalls_B", 64'(stat_stalls), 64'd5);
`endif

    // Reset mid-sweep during dev0 EVAL: no write, no done, all outputs held at zero.
    loadDev(0, mkState(16'd0, 3'd4, 18'd40, 16'd0));
    loadDev(1, mkState(16'd0, 3'd4, 18'd80, 16'd0));
    loadDev(2, mkState(16'd0, 3'd4, 18'd80, 16'd0));
    loadDev(3, mkState(16'd0, 3'd4, 18'd80, 16'd0));
    applyStimulus();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkAllZero("reset_hold");
    end
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("dev0_not_written", 64'(mem[0]), 64'(mkState(16'd0, 3'd4, 18'd40, 16'd0)));
`ifdef DIRCC_COMPUTE_STATS_EN
    checkOutput("stat_cleared", 64'({stat_updates, stat_stalls}), 64'd0);
`endif
    expectUpdate(0, 16'd1, 16'd10);
    expectUpdate(1, 16'd1, 16'd20);
    expectUpdate(2, 16'd1, 16'd20);
    expectUpdate(3, 16'd1, 16'd20);
    applyStimulus();
    waitDone("sweepC_done");

    // All devices at the iteration limit: pure skip sweep, second start while busy ignored.
    for (int d = 0; d < NUM_DEVICES; d++) loadDev(d, mkState(16'd10, 3'd4, 18'd400, 16'd0));
    max_iter = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) checkOutput("busy_after_start", 64'(busy), 64'd1);
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done) done_cyc = c;
    end
    checkOutput("done_cycle", 64'(done_cyc), 64'd17);
    @(negedge clk);
    checkOutput("idle_after_done", 64'({busy, done}), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("no_second_sweep", 64'({busy, bus.mem_rd_en}), 64'd0);
`ifdef DIRCC_COMPUTE_STATS_EN
    checkOutput("stat_updates_D", 64'(stat_updates), 64'd4);
`endif

    checkOutput("writes_drained", 64'(wr_exp.size()), 64'd0);
    checkOutput("sends_drained", 64'(send_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
